// File: rtl/lut3_pkg.sv
// Shared widths and FSM encoding for the 3-input truth-table sweep controller.
package lut3_pkg;
    localparam int IDX_W = 3;
    localparam int TBL_W = 8;
    localparam int CNT_W = 4;
    localparam int ERR_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = '1;
endpackage

// File: rtl/lut3_sweep_ctrl_if.sv
// Sweep control/status bundle plus the stimulus/response pins to the gate under test.
interface lut3_sweep_ctrl_if;
    import lut3_pkg::*;

    logic             start;
    logic             abort;
    logic [TBL_W-1:0] expected;
    logic [IDX_W-1:0] lut_in;
    logic             lut_out;
    logic             busy;
    logic             done;
    logic [TBL_W-1:0] captured;
    logic [TBL_W-1:0] mismatch;
    logic [ERR_W-1:0] err_count;
    logic             pass;

    modport master (
        output start, abort, expected, lut_out,
        input  lut_in, busy, done, captured, mismatch, err_count, pass
    );

    modport slave (
        input  start, abort, expected, lut_out,
        output lut_in, busy, done, captured, mismatch, err_count, pass
    );
endinterface

// File: rtl/popcount8.sv
// Combinational population count of an 8-bit vector (result 0..8).
module popcount8 (
    input  logic [7:0] data,
    output logic [3:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++)
            count = count + {3'd0, data[i]};
    end
endmodule

// File: rtl/lut3_sweep_ctrl.sv
// Walks lut_in through 0..7, captures the external gate's response and
// compares it against a golden truth table latched at start.
module lut3_sweep_ctrl
    import lut3_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    lut3_sweep_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [TBL_W-1:0] exp_q;
    logic [TBL_W-1:0] cap_q;
    logic [TBL_W-1:0] cap_nxt;
    logic [TBL_W-1:0] mis_q;
    logic             pass_q;

    always_comb begin
        cap_nxt      = cap_q;
        cap_nxt[idx] = bus.lut_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            cnt    <= '0;
            exp_q  <= '0;
            cap_q  <= '0;
            mis_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        exp_q  <= bus.expected;
                        cap_q  <= '0;
                        mis_q  <= '0;
                        pass_q <= 1'b0;
                        idx    <= '0;
                        cnt    <= SETTLE_RELOAD;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        // Partial capture is kept; mismatch/pass stay cleared.
                        idx   <= '0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        cap_q <= cap_nxt;
                        if (idx == IDX_LAST) begin
                            mis_q  <= cap_nxt ^ exp_q;
                            pass_q <= (cap_nxt == exp_q);
                            idx    <= '0;
                            state  <= ST_FINISH;
                        end else begin
                            idx <= idx + 1'b1;
                            cnt <= SETTLE_RELOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign bus.lut_in   = idx;
    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_FINISH);
    assign bus.captured = cap_q;
    assign bus.mismatch = mis_q;
    assign bus.pass     = pass_q;

    popcount8 u_popcount (
        .data  (mis_q),
        .count (bus.err_count)
    );
endmodule

// File: tb/tb_lut3_sweep_ctrl.sv
// Self-checking bench: vector table of sweeps with a result scoreboard, plus
// abort, reset, start-noise and short-settle sequences.
module tb_lut3_sweep_ctrl;
    import lut3_pkg::*;

    typedef struct {
        logic [7:0] gate;
        logic [7:0] exp;
        logic [7:0] cap;
        logic [7:0] mis;
        logic [3:0] errc;
        logic       pass;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, sel;
    logic [7:0] expected, gate_tbl;

    always #5 clk = ~clk;

    lut3_sweep_ctrl_if bus2 ();
    lut3_sweep_ctrl_if bus1 ();

    assign bus2.start    = start & ~sel;
    assign bus1.start    = start & sel;
    assign bus2.abort    = abort;
    assign bus1.abort    = abort;
    assign bus2.expected = expected;
    assign bus1.expected = expected;
    assign bus2.lut_out  = gate_tbl[bus2.lut_in];
    assign bus1.lut_out  = gate_tbl[bus1.lut_in];

    lut3_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    lut3_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic       m_done, m_busy, m_pass;
    logic [2:0] m_lut;
    logic [7:0] m_cap, m_mis;
    logic [3:0] m_err;

    always_comb begin
        m_done = sel ? bus1.done      : bus2.done;
        m_busy = sel ? bus1.busy      : bus2.busy;
        m_pass = sel ? bus1.pass      : bus2.pass;
        m_lut  = sel ? bus1.lut_in    : bus2.lut_in;
        m_cap  = sel ? bus1.captured  : bus2.captured;
        m_mis  = sel ? bus1.mismatch  : bus2.mismatch;
        m_err  = sel ? bus1.err_count : bus2.err_count;
    end

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Launch one sweep, push its expectation, then pop/compare when done appears.
    task automatic sweep(input vec_t v, input bit noise, input bit chg_exp);
        vec_t e;
        int   first, dones, per;
        bit   step_ok;
        per      = sel ? 2 : 3;
        gate_tbl = v.gate;
        expected = v.exp;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(v);
        first   = 0;
        dones   = 0;
        step_ok = 1'b1;
        for (int n = 1; n <= v.lat + 20; n++) begin
            @(negedge clk);
            if (n == 1 && !noise) start = 1'b0;
            if (n == 1 && chg_exp) expected = ~v.exp;
            if (m_done) begin
                dones++;
                start = 1'b0;
                if (first == 0) begin
                    first = n;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("captured", m_cap, e.cap);
                        chk("mismatch", m_mis, e.mis);
                        chk("err_count", m_err, e.errc);
                        chk("pass", m_pass, e.pass);
                    end
                end
            end else if (first == 0 && n < v.lat) begin
                if (!m_busy || m_lut !== 3'((n - 1) / per)) step_ok = 1'b0;
            end
        end
        start = 1'b0;
        if (first == 0) sb.delete();
        chk("done_latency", first, v.lat);
        chk("done_count", dones, 1);
        chk("lut_in_steps", step_ok, 1);
        chk("hold_captured", m_cap, v.cap);
        chk("hold_pass_idle", {m_pass, m_busy, m_lut}, {v.pass, 1'b0, 3'd0});
    endtask

    initial begin
        int dones;
        start = 0; abort = 0; sel = 0; expected = 0; gate_tbl = 0; rst_n = 0;
        vecs[0] = '{8'h5D, 8'h5D, 8'h5D, 8'h00, 4'd0, 1'b1, 25};
        vecs[1] = '{8'h5D, 8'h80, 8'h5D, 8'hDD, 4'd6, 1'b0, 25};
        vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 4'd8, 1'b0, 25};
        vecs[3] = '{8'hA5, 8'h5A, 8'hA5, 8'hFF, 4'd8, 1'b0, 25};
        vecs[4] = '{8'h3C, 8'h3D, 8'h3C, 8'h01, 4'd1, 1'b0, 25};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 4'd0, 1'b1, 25};

        repeat (3) @(negedge clk);
        chk("reset_dut2", {bus2.busy, bus2.done, bus2.lut_in, bus2.captured, bus2.mismatch,
                           bus2.err_count, bus2.pass}, 32'd0);
        chk("reset_dut1", {bus1.busy, bus1.done, bus1.lut_in, bus1.captured, bus1.mismatch,
                           bus1.err_count, bus1.pass}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) sweep(vecs[i], 1'b0, (i % 2) == 1);

        // start held high through RUN and FINISH
        sweep(vecs[1], 1'b1, 1'b0);

        // abort on the 10th RUN cycle
        gate_tbl = 8'h5D; expected = 8'h00;
        @(negedge clk); start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 10) abort = 1'b1;
        end
        @(negedge clk); abort = 1'b0;
        chk("abort_state", {m_busy, m_done, m_lut, m_pass, m_err}, 32'd0);
        chk("abort_partial_cap", m_cap, 8'h05);
        dones = 0;
        repeat (30) begin @(negedge clk); if (m_done) dones++; end
        chk("abort_no_done", dones, 0);
        sweep(vecs[0], 1'b0, 1'b0);

        // reset pulse mid-RUN
        gate_tbl = 8'h5D; expected = 8'h5D;
        @(negedge clk); start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("midrun_reset", {m_busy, m_done, m_lut, m_cap, m_mis, m_err, m_pass}, 32'd0);
        dones = 0;
        repeat (30) begin @(negedge clk); if (m_done || m_busy) dones++; end
        chk("reset_no_done", dones, 0);

        // start together with abort in IDLE is rejected
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", m_busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("start_abort_idle", {m_busy, m_done}, 2'd0);

        // shorter settle: lut_in steps every 2 cycles, done at T+17
        sel = 1'b1;
        sweep('{8'h5D, 8'h5D, 8'h5D, 8'h00, 4'd0, 1'b1, 17}, 1'b0, 1'b0);
        sweep('{8'hC3, 8'h00, 8'hC3, 8'hC3, 4'd4, 1'b0, 17}, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lut3_sweep_ctrl.md
LUT3_SWEEP_CTRL -- requirements
Module: lut3_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, legal 1..15: cycles each input vector is held before the output is sampled.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: sweep request, sampled in IDLE only.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels an active sweep.
REQ-006 The block SHALL have port expected, input, 8 bits: golden truth table, bit i = required output for {in3,in2,in1}=i.
REQ-007 The block SHALL have port lut_in, output, 3 bits: {in3,in2,in1} driven to the 3-input truth-table gate.
REQ-008 The block SHALL have port lut_out, input, 1 bit: the gate's output.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a sweep runs.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-011 The block SHALL have port captured, output, 8 bits: measured truth table.
REQ-012 The block SHALL have port mismatch, output, 8 bits: captured XOR latched expected.
REQ-013 The block SHALL have port err_count, output, 4 bits: population count of mismatch, 0..8.
REQ-014 The block SHALL have port pass, output, 1 bit: high when mismatch==0 after a completed sweep.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-016 In IDLE, start=1 with abort=0 at cycle T SHALL latch expected, clear captured/mismatch/err_count/pass, and enter RUN at T+1 with lut_in=0 and busy=1.
REQ-017 In RUN, each index i SHALL hold lut_in=i for SETTLE_CYCLES+1 cycles; lut_out SHALL be written into captured[i] on the last of those cycles.
REQ-018 After sampling i<7, the index SHALL increment and the settle counter reload; after sampling i=7, the FSM SHALL enter FINISH with no index wrap to 0 inside RUN.
REQ-019 FINISH SHALL last exactly one cycle with done=1, busy=0, and mismatch/err_count/pass valid; done SHALL occur at cycle T+1+8*(SETTLE_CYCLES+1); the next state SHALL be IDLE.
REQ-020 Results SHALL hold until the next accepted start.
REQ-021 start while busy SHALL be ignored, and start in FINISH SHALL be ignored.
REQ-022 expected changes during RUN SHALL not affect the result.
REQ-023 abort=1 in RUN SHALL return to IDLE next cycle with busy=0 and no done pulse; captured SHALL keep its partial contents, and pass SHALL stay 0.
REQ-024 abort=1 together with start=1 in IDLE SHALL win: the sweep is not started.
REQ-025 In IDLE, lut_in SHALL be 0.
REQ-026 err_count SHALL be computed combinationally from mismatch and SHALL never exceed 8.

Reset
REQ-027 With rst_n=0 at a rising edge, the block SHALL enter IDLE and clear lut_in, busy, done, captured, mismatch, err_count, pass, the index and the settle counter.
REQ-028 Reset mid-RUN SHALL discard the sweep, and no done SHALL be issued.

Structure
REQ-029 The state encoding (IDLE/RUN/FINISH), the index width (3) and the table width (8) SHALL live in shared package lut3_pkg.
REQ-030 Population count SHALL be one sub-module, popcount8 (8-bit in, 4-bit out, combinational).
REQ-031 The gate under test SHALL be external; the block SHALL not instantiate it.

Verification
REQ-032 Scenario 1: SETTLE_CYCLES=2, gate table 8'h5D, expected=8'h5D, start at T -> done at T+25, captured=8'h5D, mismatch=0, err_count=0, pass=1.
REQ-033 Scenario 2: gate 8'h5D, expected=8'h80 -> captured=8'h5D, mismatch=8'hDD, err_count=6, pass=0.
REQ-034 Scenario 3: abort at the 10th RUN cycle -> busy=0 next cycle, no done, lut_in=0; a following start runs a full sweep normally.
REQ-035 Scenario 4: start pulsed repeatedly during RUN and in FINISH -> exactly one done, timing unchanged.
REQ-036 Scenario 5: rst_n=0 for one cycle mid-RUN -> all outputs 0 next cycle, no done; start+abort together in IDLE -> busy stays 0.
REQ-037 Scenario 6: SETTLE_CYCLES=1 -> lut_in steps every 2 cycles 0..7, done at T+17.
